// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared widths, limits and helpers for the PID drive controller
package pid_pkg;

  localparam int ERR_W   = 13;
  localparam int INTEG_W = 18;
  localparam int DRV_W   = 12;
  localparam int CNT_W   = 20;

  localparam logic [INTEG_W-1:0] INTEG_MAX = 18'h1FFFF;

  // Derivative saturation limits, held at the 14-bit width of the raw difference
  localparam logic signed [13:0] D_SAT_MAX = 14'sd511;
  localparam logic signed [13:0] D_SAT_MIN = -14'sd512;

  // Largest drive magnitude, at the 15-bit width of the PID sum
  localparam logic signed [14:0] DRV_MAX = 15'sd4095;

  // Decimation masks: tick fires when every masked counter bit is one
  localparam logic [CNT_W-1:0] TICK_MASK_FAST = 20'h07FFF;
  localparam logic [CNT_W-1:0] TICK_MASK_FULL = 20'hFFFFF;

  function automatic logic signed [9:0] sat_diff(input logic signed [13:0] d);
    if (d > D_SAT_MAX) begin
      return D_SAT_MAX[9:0];
    end else if (d < D_SAT_MIN) begin
      return D_SAT_MIN[9:0];
    end else begin
      return d[9:0];
    end
  endfunction

endpackage

// File: rtl/pid_integrator.sv
// rtl/pid_integrator.sv - clamped decimated integrator of the current error
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   tick           decimation strobe; accumulate error when high
//   not_pedaling   clears the integrator; wins over tick
//   error          signed 13-bit current error
//   integ          18-bit integrator, always within [0, 0x1FFFF]
module pid_integrator
  import pid_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      not_pedaling,
  input  logic signed [ERR_W-1:0]   error,
  output logic signed [INTEG_W-1:0] integ
);

  // One extra bit so the add cannot wrap before the clamp looks at it
  logic signed [INTEG_W:0]   sum;
  logic signed [INTEG_W-1:0] clamped;

  assign sum = {integ[INTEG_W-1], integ} + {{(INTEG_W+1-ERR_W){error[ERR_W-1]}}, error};

  always_comb begin
    clamped = sum[INTEG_W-1:0];
    if (sum[INTEG_W]) begin
      clamped = '0;
    end else if (sum > $signed({1'b0, INTEG_MAX})) begin
      clamped = INTEG_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
    end else if (not_pedaling) begin
      integ <= '0;
    end else if (tick) begin
      integ <= clamped;
    end
  end

endmodule

// File: rtl/pid_ctrl.sv
// rtl/pid_ctrl.sv - PID controller producing motor drive magnitude from current error
//
// Optional derivative path enabled by macro PID_D_TERM_EN.
//
// Parameters:
//   FAST_SIM       1: 15-bit decimation period, 0: full 20-bit period
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   error          signed 13-bit target minus average current
//   not_pedaling   high while the rider is not pedaling
//   drv_mag        unsigned 12-bit drive magnitude, registered
module pid_ctrl
  import pid_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    not_pedaling,
  output logic [DRV_W-1:0]        drv_mag
);

  localparam logic [CNT_W-1:0] TICK_MASK = (FAST_SIM != 0) ? TICK_MASK_FAST : TICK_MASK_FULL;

  logic [CNT_W-1:0]          cnt;
  logic                      tick;
  logic signed [INTEG_W-1:0] integ;
  logic signed [13:0]        p_term;
  logic signed [13:0]        i_term;
  logic signed [13:0]        d_term;
  logic signed [14:0]        pid_sum;
  logic [DRV_W-1:0]          drv_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = ((cnt & TICK_MASK) == TICK_MASK);

  pid_integrator u_integ (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .not_pedaling (not_pedaling),
    .error        (error),
    .integ        (integ)
  );

  assign p_term = {error[ERR_W-1], error};

  // Integrator sign bit is always 0 after the clamp; the low five bits are sub-LSB
  assign i_term = {2'b00, integ[16:5]};

  logic unused_integ_bits;
  assign unused_integ_bits = &{1'b0, integ[INTEG_W-1], integ[4:0]};

`ifdef PID_D_TERM_EN
  logic signed [ERR_W-1:0] prev_err;
  logic signed [13:0]      diff;
  logic signed [9:0]       diff_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_err <= '0;
    end else if (tick) begin
      prev_err <= error;
    end
  end

  assign diff     = {error[ERR_W-1], error} - {prev_err[ERR_W-1], prev_err};
  assign diff_sat = sat_diff(diff);
  assign d_term   = {{3{diff_sat[9]}}, diff_sat, 1'b0};
`else
  assign d_term = '0;
`endif

  // 15 bits hold the worst case 4095 + 4095 + 1022 and -4096 - 1024
  assign pid_sum = {p_term[13], p_term} + {i_term[13], i_term} + {d_term[13], d_term};

  always_comb begin
    drv_next = pid_sum[DRV_W-1:0];
    if (pid_sum[14]) begin
      drv_next = '0;
    end else if (pid_sum > DRV_MAX) begin
      drv_next = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_mag <= '0;
    end else begin
      drv_mag <= drv_next;
    end
  end

endmodule
